clk_gen_multi_divider: RTL and testbench
========================================

Name: clk_gen_multi_divider

Overview:
Multi-channel programmable integer clock divider, generalising the power-of-two counter-tap divider.
- Each of CH channels divides clk_gen_fsys by an arbitrary integer D in 2..2^DIV_W-1.
- Per channel it produces a registered divided clock (clk_gen_out) and a single-cycle enable pulse (clk_gen_tick), intended for downstream logic clocked on clk_gen_fsys.
- Divisor changes are glitch-free: they apply only at a period boundary.
- A global sync input realigns the phase of all channels.

Parameters:
CH, 4, number of independent channels (≥1)
DIV_W, 16, divisor and counter width per channel
DEFAULT_DIV, 2, active divisor after reset (must be ≥2 and <2^DIV_W)

Ports:
clk_gen_fsys  input  1  system clock; all logic on its rising edge
clk_gen_rst  input  1  synchronous, active-high reset
clk_gen_en  input  CH  per-channel run enable
clk_gen_sync  input  1  global phase restart pulse
clk_gen_load  input  CH  per-channel divisor load strobe
clk_gen_div  input  CH*DIV_W  divisor values; channel i uses bits [i*DIV_W +: DIV_W]
clk_gen_out  output  CH  registered divided clocks
clk_gen_tick  output  CH  registered one-cycle pulse at end of each period
clk_gen_pend  output  CH  registered flag: a loaded divisor is waiting for a boundary

Behaviour:
- One clock; reset is synchronous and active-high, named clk_gen_rst, sampled on the rising edge of clk_gen_fsys.
- Per-channel state: cnt[DIV_W], div_act[DIV_W], div_pend[DIV_W], pend.
- Reset values: cnt=0, div_act=DEFAULT_DIV, div_pend=0, pend=0, clk_gen_out=0, clk_gen_tick=0, clk_gen_pend=0. Reset overrides every other input.
- Load clamp: a loaded value of 0 or 1 is stored as 2.
- Load when no terminal count: div_pend<=clamped value, pend<=1. A load while pend=1 overwrites div_pend (last load wins).
- Running (en=1, sync=0):
  - If cnt==div_act-1: cnt<=0. If pend=1, div_act<=div_pend and pend<=0.
  - Otherwise: cnt<=cnt+1.
- Load in the same cycle as terminal count: the new value goes directly to div_act and pend<=0. The new divisor governs the very next period.
- Outputs (registered, one-cycle lag from cnt):
  - clk_gen_out <= (cnt >= div_act>>1). Gives floor(D/2) cycles low, then ceil(D/2) cycles high.
  - clk_gen_tick <= (cnt == div_act-1).
  - tick therefore coincides with the last high cycle of out.
- Disabled (en=0): cnt<=0, out<=0, tick<=0. Any pending divisor is applied immediately (div_act<=div_pend, pend<=0). A load strobe in the same cycle is applied directly.
- Re-enable: the first period starts from cnt=0; out is low for floor(D/2) cycles.
- Sync (sync=1): every enabled channel sets cnt<=0, applies pending, out<=0, tick<=0. Sync has priority over load/terminal handling, except that a load in the same cycle is applied directly.
- clk_gen_pend mirrors pend, registered.
- Counter never exceeds div_act-1. No combinational path from any input to any output.
- Channels are fully independent apart from sync and reset.

Test Plan:
- Reset, then en=1 on channel 0 with DEFAULT_DIV=2 -> out0 toggles every cycle (0,0,1,0,1…), tick0 high each cycle out0=1.
- Load D=5 on channel 1, en=1 -> steady state out1 period 5: 2 low, 3 high; tick1 one pulse every 5 cycles, aligned with the 3rd high cycle.
- Channel 1 running D=5, load D=3 at cnt=1 -> pend1=1 until wrap; current period finishes at 5 cycles, next periods are 3 cycles (1 low, 2 high); pend1 clears at the wrap cycle.
- Load 0 and load 1 -> behaves as D=2. Load 65535 with DIV_W=16 -> period 65535, tick spacing 65535.
- Channels 0–3 at D=4,6,8,10; assert sync for one cycle mid-period -> all outs low next cycle; every channel's first tick occurs exactly D cycles after sync.
- Drop en mid-period, then assert rst mid-period, then load during en=0 -> out/tick zero; new divisor active on re-enable; rst restores DEFAULT_DIV and clears pend.

Source files
------------

// File: rtl/clk_gen_multi_divider_if.sv
// Control and status bundle for the multi-channel clock divider.
// Per-channel fields are packed CH wide; divisors are packed DIV_W per channel.
interface clk_gen_multi_divider_if #(
  parameter int CH    = 4,
  parameter int DIV_W = 16
);
  logic [CH-1:0]       clk_gen_en;
  logic                clk_gen_sync;
  logic [CH-1:0]       clk_gen_load;
  logic [CH*DIV_W-1:0] clk_gen_div;
  logic [CH-1:0]       clk_gen_out;
  logic [CH-1:0]       clk_gen_tick;
  logic [CH-1:0]       clk_gen_pend;

  modport master (
    output clk_gen_en, clk_gen_sync, clk_gen_load, clk_gen_div,
    input  clk_gen_out, clk_gen_tick, clk_gen_pend
  );

  modport slave (
    input  clk_gen_en, clk_gen_sync, clk_gen_load, clk_gen_div,
    output clk_gen_out, clk_gen_tick, clk_gen_pend
  );
endinterface

// File: rtl/clk_gen_multi_divider.sv
// CH independent integer dividers of clk_gen_fsys with glitch-free divisor swap and global phase sync.
// Outputs registered, one cycle behind the period counter; no backpressure.
module clk_gen_multi_divider #(
  parameter int CH          = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                     clk_gen_fsys,
  input  logic                     clk_gen_rst,
  clk_gen_multi_divider_if.slave   bus
);

  logic [CH-1:0] out_v;
  logic [CH-1:0] tick_v;
  logic [CH-1:0] pend_v;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_pend;
    logic [DIV_W-1:0] div_in;
    logic [DIV_W-1:0] div_clamp;
    logic [DIV_W-1:0] last;
    logic             pend;
    logic             out_q;
    logic             tick_q;
    logic             at_end;
    logic             restart;
    logic             load;

    assign div_in    = bus.clk_gen_div[i*DIV_W +: DIV_W];
    // Divide-by-0/1 is meaningless; treat it as the fastest legal rate.
    assign div_clamp = (div_in < DIV_W'(2)) ? DIV_W'(2) : div_in;
    assign last      = div_act - DIV_W'(1);
    assign at_end    = (cnt == last);
    assign restart   = ~bus.clk_gen_en[i] | bus.clk_gen_sync;
    assign load      = bus.clk_gen_load[i];

    always_ff @(posedge clk_gen_fsys) begin
      if (clk_gen_rst) begin
        cnt      <= '0;
        div_act  <= DIV_W'(DEFAULT_DIV);
        div_pend <= '0;
        pend     <= 1'b0;
        out_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else if (restart) begin
        // Idle or resynchronising: safe point to take any new divisor.
        cnt    <= '0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
        if (load) begin
          div_act <= div_clamp;
          pend    <= 1'b0;
        end else if (pend) begin
          div_act <= div_pend;
          pend    <= 1'b0;
        end
      end else begin
        out_q  <= (cnt >= (div_act >> 1));
        tick_q <= at_end;
        if (at_end) begin
          cnt <= '0;
          if (load) begin
            div_act <= div_clamp;
            pend    <= 1'b0;
          end else if (pend) begin
            div_act <= div_pend;
            pend    <= 1'b0;
          end
        end else begin
          cnt <= cnt + DIV_W'(1);
          if (load) begin
            div_pend <= div_clamp;
            pend     <= 1'b1;
          end
        end
      end
    end

    assign out_v[i]  = out_q;
    assign tick_v[i] = tick_q;
    assign pend_v[i] = pend;
  end

  assign bus.clk_gen_out  = out_v;
  assign bus.clk_gen_tick = tick_v;
  assign bus.clk_gen_pend = pend_v;

endmodule

// File: tb/tb_clk_gen_multi_divider.sv
// Randomised and directed bench for clk_gen_multi_divider against a period-position reference model.
module tb_clk_gen_multi_divider;
  localparam int CH          = 4;
  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 2;

  logic clk_gen_fsys = 1'b0;
  logic clk_gen_rst;
  always #5 clk_gen_fsys = ~clk_gen_fsys;

  clk_gen_multi_divider_if #(.CH(CH), .DIV_W(DIV_W)) bus ();

  clk_gen_multi_divider #(.CH(CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk_gen_fsys (clk_gen_fsys),
    .clk_gen_rst  (clk_gen_rst),
    .bus          (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model: position within the current period, its length, and a queued next length.
  int m_pos[CH];
  int m_per[CH];
  int m_next[CH];
  bit m_has_next[CH];
  bit m_out[CH];
  bit m_tick[CH];

  function automatic logic [3*CH-1:0] model_vec();
    logic [CH-1:0] o, t, p;
    for (int c = 0; c < CH; c++) begin
      o[c] = m_out[c];
      t[c] = m_tick[c];
      p[c] = m_has_next[c];
    end
    return {o, t, p};
  endfunction

  task automatic set_div(input int c, input int v);
    bus.clk_gen_div[c*DIV_W +: DIV_W] = DIV_W'(v);
  endtask

  // Advance the model with the inputs presented at this edge, then the clock.
  task automatic step();
    for (int c = 0; c < CH; c++) begin
      int  req;
      bit  ld;
      req = int'(bus.clk_gen_div[c*DIV_W +: DIV_W]);
      if (req < 2) req = 2;
      ld = bus.clk_gen_load[c];
      if (clk_gen_rst) begin
        m_pos[c] = 0; m_per[c] = DEFAULT_DIV; m_next[c] = 0;
        m_has_next[c] = 0; m_out[c] = 0; m_tick[c] = 0;
      end else if (!bus.clk_gen_en[c] || bus.clk_gen_sync) begin
        m_pos[c] = 0; m_out[c] = 0; m_tick[c] = 0;
        if (ld) begin m_per[c] = req; m_has_next[c] = 0; end
        else if (m_has_next[c]) begin m_per[c] = m_next[c]; m_has_next[c] = 0; end
      end else begin
        m_out[c]  = (m_pos[c] >= m_per[c] / 2);
        m_tick[c] = (m_pos[c] == m_per[c] - 1);
        if (m_tick[c]) begin
          m_pos[c] = 0;
          if (ld) begin m_per[c] = req; m_has_next[c] = 0; end
          else if (m_has_next[c]) begin m_per[c] = m_next[c]; m_has_next[c] = 0; end
        end else begin
          m_pos[c]++;
          if (ld) begin m_next[c] = req; m_has_next[c] = 1; end
        end
      end
    end
    @(posedge clk_gen_fsys);
    #1;
  endtask

  task automatic test_reset();
    clk_gen_rst = 1'b1;
    bus.clk_gen_en = '1;
    bus.clk_gen_sync = 1'b0;
    bus.clk_gen_load = '1;
    for (int c = 0; c < CH; c++) set_div(c, $urandom_range(0, 50));
    step();
    step();
    compared++;
    if (bus.clk_gen_out !== '0) begin
      mismatched++; $display("FAIL reset_out got %b exp 0", bus.clk_gen_out);
    end
    compared++;
    if (bus.clk_gen_tick !== '0) begin
      mismatched++; $display("FAIL reset_tick got %b exp 0", bus.clk_gen_tick);
    end
    compared++;
    if (bus.clk_gen_pend !== '0) begin
      mismatched++; $display("FAIL reset_pend got %b exp 0", bus.clk_gen_pend);
    end
    clk_gen_rst = 1'b0;
    bus.clk_gen_load = '0;
    bus.clk_gen_en = '0;
    step();
    compared++;
    if ({bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend} !== model_vec()) begin
      mismatched++; $display("FAIL reset_idle got %h exp %h", {bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend}, model_vec());
    end
  endtask

  task automatic test_div2();
    bus.clk_gen_en = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      bit e;
      step();
      e = (k % 2) == 1;
      compared++;
      if (bus.clk_gen_out[0] !== e || bus.clk_gen_tick[0] !== e) begin
        mismatched++;
        $display("FAIL div2 k=%0d got out=%b tick=%b exp %b", k, bus.clk_gen_out[0], bus.clk_gen_tick[0], e);
      end
      compared++;
      if ({bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend} !== model_vec()) begin
        mismatched++; $display("FAIL div2_model got %h exp %h", {bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend}, model_vec());
      end
    end
  endtask

  task automatic test_div5();
    set_div(1, 5);
    bus.clk_gen_load = 4'b0010;
    step();
    bus.clk_gen_load = '0;
    bus.clk_gen_en[1] = 1'b1;
    for (int k = 0; k < 25; k++) begin
      bit eo, et;
      step();
      eo = (k % 5) >= 2;
      et = (k % 5) == 4;
      compared++;
      if (bus.clk_gen_out[1] !== eo || bus.clk_gen_tick[1] !== et) begin
        mismatched++;
        $display("FAIL div5 k=%0d got out=%b tick=%b exp out=%b tick=%b", k, bus.clk_gen_out[1], bus.clk_gen_tick[1], eo, et);
      end
      compared++;
      if ({bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend} !== model_vec()) begin
        mismatched++; $display("FAIL div5_model got %h exp %h", {bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend}, model_vec());
      end
    end
  endtask

  task automatic test_change();
    for (int i = 0; i < 20 && m_pos[1] != 1; i++) step();
    compared++;
    if (m_pos[1] != 1) begin
      mismatched++; $display("FAIL change_wait got pos=%0d exp 1", m_pos[1]);
    end
    set_div(1, 3);
    bus.clk_gen_load[1] = 1'b1;
    step();
    bus.clk_gen_load = '0;
    compared++;
    if (bus.clk_gen_pend[1] !== 1'b1) begin
      mismatched++; $display("FAIL change_pend_set got %b exp 1", bus.clk_gen_pend[1]);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      compared++;
      if (bus.clk_gen_tick[1] !== (k == 3) || bus.clk_gen_pend[1] !== (k != 3)) begin
        mismatched++;
        $display("FAIL change_wrap k=%0d got tick=%b pend=%b", k, bus.clk_gen_tick[1], bus.clk_gen_pend[1]);
      end
    end
    for (int j = 1; j <= 6; j++) begin
      bit eo, et;
      step();
      eo = ((j - 1) % 3) >= 1;
      et = (j % 3) == 0;
      compared++;
      if (bus.clk_gen_out[1] !== eo || bus.clk_gen_tick[1] !== et) begin
        mismatched++;
        $display("FAIL change_div3 j=%0d got out=%b tick=%b exp out=%b tick=%b", j, bus.clk_gen_out[1], bus.clk_gen_tick[1], eo, et);
      end
      compared++;
      if ({bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend} !== model_vec()) begin
        mismatched++; $display("FAIL change_model got %h exp %h", {bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend}, model_vec());
      end
    end
  endtask

  task automatic test_clamp();
    int gap;
    bit seen;
    set_div(2, 0);
    set_div(3, 1);
    bus.clk_gen_load = 4'b1100;
    step();
    bus.clk_gen_load = '0;
    bus.clk_gen_en[3:2] = 2'b11;
    for (int j = 0; j < 8; j++) begin
      bit et;
      step();
      et = (j % 2) == 1;
      compared++;
      if (bus.clk_gen_tick[2] !== et || bus.clk_gen_tick[3] !== et) begin
        mismatched++;
        $display("FAIL clamp j=%0d got tick2=%b tick3=%b exp %b", j, bus.clk_gen_tick[2], bus.clk_gen_tick[3], et);
      end
    end
    set_div(0, 65535);
    bus.clk_gen_load[0] = 1'b1;
    step();
    bus.clk_gen_load = '0;
    seen = bus.clk_gen_tick[0];
    for (int i = 0; i < 3 && !seen; i++) begin
      step();
      seen = bus.clk_gen_tick[0];
    end
    compared++;
    if (!seen) begin
      mismatched++; $display("FAIL max_first_tick got none exp tick within 3");
    end
    gap = 0;
    seen = 0;
    while (!seen && gap < 70000) begin
      step();
      gap++;
      seen = bus.clk_gen_tick[0];
      if ({bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend} !== model_vec()) begin
        compared++;
        mismatched++;
        $display("FAIL max_model gap=%0d got %h exp %h", gap, {bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend}, model_vec());
      end
    end
    compared++;
    if (gap != 65535) begin
      mismatched++; $display("FAIL max_spacing got %0d exp 65535", gap);
    end
  endtask

  task automatic test_sync();
    int dv[CH];
    int first[CH];
    bus.clk_gen_en = '0;
    for (int c = 0; c < CH; c++) begin
      dv[c] = 4 + 2 * c;
      set_div(c, dv[c]);
      first[c] = 0;
    end
    bus.clk_gen_load = '1;
    step();
    bus.clk_gen_load = '0;
    bus.clk_gen_en = '1;
    repeat ($urandom_range(3, 20)) step();
    bus.clk_gen_sync = 1'b1;
    step();
    bus.clk_gen_sync = 1'b0;
    compared++;
    if (bus.clk_gen_out !== '0 || bus.clk_gen_tick !== '0) begin
      mismatched++; $display("FAIL sync_clear got out=%b tick=%b exp 0", bus.clk_gen_out, bus.clk_gen_tick);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      for (int c = 0; c < CH; c++)
        if (first[c] == 0 && bus.clk_gen_tick[c]) first[c] = k;
      compared++;
      if ({bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend} !== model_vec()) begin
        mismatched++; $display("FAIL sync_model k=%0d got %h exp %h", k, {bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend}, model_vec());
      end
    end
    for (int c = 0; c < CH; c++) begin
      compared++;
      if (first[c] != dv[c]) begin
        mismatched++; $display("FAIL sync_first_tick ch%0d got %0d exp %0d", c, first[c], dv[c]);
      end
    end
  endtask

  task automatic test_disable_reset();
    step();
    set_div(2, 5);
    bus.clk_gen_load[2] = 1'b1;
    step();
    bus.clk_gen_load = '0;
    step();
    bus.clk_gen_en[2] = 1'b0;
    step();
    compared++;
    if (bus.clk_gen_out[2] !== 1'b0 || bus.clk_gen_tick[2] !== 1'b0 || bus.clk_gen_pend[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL disable got out=%b tick=%b pend=%b exp 0", bus.clk_gen_out[2], bus.clk_gen_tick[2], bus.clk_gen_pend[2]);
    end
    set_div(2, 7);
    bus.clk_gen_load[2] = 1'b1;
    step();
    bus.clk_gen_load = '0;
    bus.clk_gen_en[2] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      compared++;
      if (bus.clk_gen_out[2] !== (k >= 4) || bus.clk_gen_tick[2] !== (k == 7)) begin
        mismatched++;
        $display("FAIL reenable k=%0d got out=%b tick=%b", k, bus.clk_gen_out[2], bus.clk_gen_tick[2]);
      end
    end
    set_div(1, 9);
    bus.clk_gen_load[1] = 1'b1;
    step();
    bus.clk_gen_load = '0;
    step();
    clk_gen_rst = 1'b1;
    step();
    clk_gen_rst = 1'b0;
    compared++;
    if ({bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend} !== '0) begin
      mismatched++; $display("FAIL midrun_reset got %h exp 0", {bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend});
    end
    for (int j = 1; j <= 6; j++) begin
      step();
      compared++;
      if (bus.clk_gen_tick[1] !== ((j % 2) == 0) || bus.clk_gen_pend[1] !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_default j=%0d got tick=%b pend=%b", j, bus.clk_gen_tick[1], bus.clk_gen_pend[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.clk_gen_en   = CH'($urandom_range(0, 15)) | CH'($urandom_range(0, 15));
      bus.clk_gen_sync = ($urandom_range(0, 29) == 0);
      bus.clk_gen_load = '0;
      for (int c = 0; c < CH; c++) begin
        bus.clk_gen_load[c] = ($urandom_range(0, 9) == 0);
        set_div(c, $urandom_range(0, 12));
      end
      clk_gen_rst = ($urandom_range(0, 199) == 0);
      step();
      compared++;
      if ({bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend} !== model_vec()) begin
        mismatched++; $display("FAIL random n=%0d got %h exp %h", n, {bus.clk_gen_out, bus.clk_gen_tick, bus.clk_gen_pend}, model_vec());
      end
    end
    clk_gen_rst = 1'b0;
    bus.clk_gen_sync = 1'b0;
    bus.clk_gen_load = '0;
  endtask

  initial begin
    clk_gen_rst = 1'b1;
    bus.clk_gen_en = '0;
    bus.clk_gen_sync = 1'b0;
    bus.clk_gen_load = '0;
    bus.clk_gen_div = '0;
    for (int c = 0; c < CH; c++) begin
      m_pos[c] = 0; m_per[c] = DEFAULT_DIV; m_next[c] = 0;
      m_has_next[c] = 0; m_out[c] = 0; m_tick[c] = 0;
    end
    test_reset();
    test_div2();
    test_div5();
    test_change();
    test_clamp();
    test_sync();
    test_disable_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
